irs_block_reader: RTL and testbench
===================================

# irs_block_reader

Read-side sequencer for the IRS digitizer: accepts a block read request, drives the block read address to the chip, runs the Wilkinson conversion and walks the sample selects. Each converted sample is then handed downstream over a valid/ready stream. It is the read-end counterpart of the write-address path and sits between the readout controller and the IRS pins.

## Interface
- NUM_SAMPLES, 64, samples read per block (power of two, ≤64)
- SETTLE_CYCLES, 8, cycles RDADDR/RDEN held before conversion starts (≥1)
- CONV_CYCLES, 256, Wilkinson ramp/count duration in cycles (≥1)
- SMP_WAIT, 2, cycles between SMPSEL change and data capture (≥1)

- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- rd_req_i  in  1  read request, level; sampled in IDLE only
- rd_block_i  in  9  block address to read, captured with request
- rd_ack_o  out  1  one-cycle pulse: request accepted
- busy_o  out  1  high from acceptance until return to IDLE
- irs_rdaddr_o  out  9  block read address to chip
- irs_rden_o  out  1  read enable to chip
- irs_ramp_o  out  1  Wilkinson ramp
- irs_start_o  out  1  Wilkinson counter start
- irs_smpsel_o  out  6  sample select
- irs_dat_i  in  12  converted sample data from chip
- dat_o  out  12  sample data downstream
- dat_valid_o  out  1  dat_o valid
- dat_last_o  out  1  marks final sample of block
- dat_ready_i  in  1  downstream accepts when high with valid

## Operation
- All outputs registered; reset value 0 for every output.
- States: IDLE, SETTLE, CONVERT, SELECT, CAPTURE, HANDOFF, DONE.
- IDLE: on rd_req_i=1, latch rd_block_i, pulse rd_ack_o, go SETTLE. busy_o=1 from the next cycle.
- SETTLE: irs_rdaddr_o=latched block, irs_rden_o=1; after SETTLE_CYCLES go CONVERT.
- CONVERT: irs_ramp_o=1 and irs_start_o=1 for CONV_CYCLES; both drop on exit; go SELECT with sample index 0.
- SELECT: drive irs_smpsel_o=index; wait SMP_WAIT cycles; go CAPTURE.
- CAPTURE: register irs_dat_i into dat_o, assert dat_valid_o; dat_last_o=1 iff index=NUM_SAMPLES-1; go HANDOFF.
- HANDOFF: hold dat_o/valid/last stable until dat_ready_i=1. On the handshake cycle: if last, go DONE; else increment index, go SELECT. valid drops the cycle after the handshake.
- DONE: irs_rden_o, irs_rdaddr_o, irs_smpsel_o, busy_o to 0; return IDLE. The earliest next acceptance is 1 cycle later.
- rd_req_i held high re-requests; each accepted request produces exactly one rd_ack_o.
- Index counter is 6 bits; wrap never occurs (terminated by last).
- rst_i mid-operation: next edge forces IDLE, all outputs 0, any partial block discarded with no last emitted.

## Timing
- Request accepted cycle T: rd_ack_o=1 at T+1; irs_rden_o=1 from T+2.
- First dat_valid_o at T+2+SETTLE_CYCLES+CONV_CYCLES+SMP_WAIT+1.
- Per sample with ready tied high: 1 (handoff) + SMP_WAIT + 1 (capture) = SMP_WAIT+2 cycles.
- irs_smpsel_o changes only on SELECT entry; never while dat_valid_o=1 awaits ready.
- Single shared countdown counter, reloaded on each state entry with (N-1).

## Configuration
- IRS_RD_TESTPATTERN_EN defined: CAPTURE loads dat_o = {latched block[5:0], index[5:0]} instead of irs_dat_i. All sequencing and pin activity are unchanged.
- Undefined: dat_o = irs_dat_i. No test-pattern logic is synthesized.

## Structure
- Package irs_rd_pkg: state enum, IRS_BLOCK_W=9, IRS_SMP_W=6, IRS_DAT_W=12.
- Sub-module irs_cycle_counter: loadable down-counter with a zero flag, shared across SETTLE/CONVERT/SELECT waits.

## Test plan
- Defaults, ready=1, request block 0x1A5: ack 1 cycle; rdaddr=0x1A5 for 8+256+… cycles; 64 samples, last on sample 63, rden low after DONE.
- Downstream stall: ready=0 for 10 cycles on sample 5: dat_o/valid stable, smpsel stays 5, no sample lost or duplicated.
- rd_req_i held high across two blocks: exactly two acks, the second ≥1 cycle after the first block's DONE.
- rst_i asserted in CONVERT and again in HANDOFF: next cycle all outputs 0, state IDLE, new request then completes normally.
- IRS_RD_TESTPATTERN_EN, block 0x03F: dat_o sequence 0xFC0..0xFFF (block[5:0]=0x3F in upper bits, index in lower bits).
- NUM_SAMPLES=4, SMP_WAIT=1, irs_dat_i driven = smpsel*3: dat_o 0,3,6,9, last on 9, first valid at T+2+8+256+2.

Source files
------------

// File: rtl/irs_rd_pkg.sv
// Shared types and widths for the IRS read-side sequencer.
package irs_rd_pkg;

  localparam int IRS_BLOCK_W = 9;
  localparam int IRS_SMP_W   = 6;
  localparam int IRS_DAT_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_SELECT  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_HANDOFF = 3'd5,
    ST_DONE    = 3'd6
  } irs_rd_state_e;

  // Largest of the three wait lengths; sizes the shared countdown.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/irs_cycle_counter.sv
// Loadable down-counter with zero flag; one instance times every wait state
// of the block reader.
module irs_cycle_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] count_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/irs_block_reader.sv
// IRS block read sequencer: settle, Wilkinson convert, walk sample selects and
// stream each sample out. Define IRS_RD_TESTPATTERN_EN to emit {block,index}.
module irs_block_reader
  import irs_rd_pkg::*;
#(
  parameter int NUM_SAMPLES   = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int CONV_CYCLES   = 256,
  parameter int SMP_WAIT      = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_req_i,
  input  logic [IRS_BLOCK_W-1:0] rd_block_i,
  output logic                   rd_ack_o,
  output logic                   busy_o,
  output logic [IRS_BLOCK_W-1:0] irs_rdaddr_o,
  output logic                   irs_rden_o,
  output logic                   irs_ramp_o,
  output logic                   irs_start_o,
  output logic [IRS_SMP_W-1:0]   irs_smpsel_o,
  input  logic [IRS_DAT_W-1:0]   irs_dat_i,
  output logic [IRS_DAT_W-1:0]   dat_o,
  output logic                   dat_valid_o,
  output logic                   dat_last_o,
  input  logic                   dat_ready_i
);

  localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, CONV_CYCLES, SMP_WAIT) + 1);

  localparam logic [CNT_W-1:0]       SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CONV_LOAD   = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0]       SMP_LOAD    = CNT_W'(SMP_WAIT - 1);
  localparam logic [CNT_W-1:0]       CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [IRS_SMP_W-1:0]   LAST_IDX    = IRS_SMP_W'(NUM_SAMPLES - 1);
  localparam logic [IRS_SMP_W-1:0]   SMP_ZERO    = {IRS_SMP_W{1'b0}};
  localparam logic [IRS_SMP_W-1:0]   SMP_ONE     = IRS_SMP_W'(1);
  localparam logic [IRS_BLOCK_W-1:0] BLOCK_ZERO  = {IRS_BLOCK_W{1'b0}};
  localparam logic [IRS_DAT_W-1:0]   DAT_ZERO    = {IRS_DAT_W{1'b0}};

  irs_rd_state_e          state_r;
  irs_rd_state_e          state_next_s;
  logic [IRS_BLOCK_W-1:0] block_r;
  logic [IRS_BLOCK_W-1:0] block_next_s;
  logic [IRS_SMP_W-1:0]   index_r;
  logic [IRS_SMP_W-1:0]   index_next_s;

  logic                   cnt_load_s;
  logic [CNT_W-1:0]       cnt_val_s;
  logic                   cnt_zero_s;

  logic [IRS_DAT_W-1:0]   cap_dat_s;
  logic                   ack_next_s;
  logic                   busy_next_s;
  logic                   rden_next_s;
  logic [IRS_BLOCK_W-1:0] rdaddr_next_s;
  logic                   ramp_next_s;
  logic [IRS_SMP_W-1:0]   smpsel_next_s;
  logic [IRS_DAT_W-1:0]   dat_next_s;
  logic                   valid_next_s;
  logic                   last_next_s;

  irs_cycle_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

`ifdef IRS_RD_TESTPATTERN_EN
  assign cap_dat_s = {block_r[5:0], index_r};
`else
  assign cap_dat_s = irs_dat_i;
`endif

  // FSM state, latched block address and sample index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      block_r <= BLOCK_ZERO;
      index_r <= SMP_ZERO;
    end else begin
      state_r <= state_next_s;
      block_r <= block_next_s;
      index_r <= index_next_s;
    end
  end

  // Next-state, counter reloads and downstream data path.
  // The ack cycle stays in IDLE so the chip pins follow one cycle after ack.
  always_comb begin
    state_next_s = state_r;
    block_next_s = block_r;
    index_next_s = index_r;
    ack_next_s   = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_val_s    = CNT_ZERO;
    dat_next_s   = dat_o;
    valid_next_s = dat_valid_o;
    last_next_s  = dat_last_o;
    case (state_r)
      ST_IDLE: begin
        if (rd_ack_o) begin
          state_next_s = ST_SETTLE;
          cnt_load_s   = 1'b1;
          cnt_val_s    = SETTLE_LOAD;
        end else if (rd_req_i) begin
          ack_next_s   = 1'b1;
          block_next_s = rd_block_i;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
          state_next_s = ST_CONVERT;
          cnt_load_s   = 1'b1;
          cnt_val_s    = CONV_LOAD;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end
      ST_CONVERT: begin
        if (cnt_zero_s) begin
          state_next_s = ST_SELECT;
          index_next_s = SMP_ZERO;
          cnt_load_s   = 1'b1;
          cnt_val_s    = SMP_LOAD;
        end else begin
          state_next_s = ST_CONVERT;
        end
      end
      ST_SELECT: begin
        if (cnt_zero_s) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_SELECT;
        end
      end
      ST_CAPTURE: begin
        dat_next_s   = cap_dat_s;
        valid_next_s = 1'b1;
        last_next_s  = (index_r == LAST_IDX);
        state_next_s = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (dat_valid_o && dat_ready_i) begin
          valid_next_s = 1'b0;
          last_next_s  = 1'b0;
          if (dat_last_o) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_SELECT;
            index_next_s = index_r + SMP_ONE;
            cnt_load_s   = 1'b1;
            cnt_val_s    = SMP_LOAD;
          end
        end else begin
          state_next_s = ST_HANDOFF;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Pin values decoded from the state being entered, so pins stay aligned with it.
  always_comb begin
    busy_next_s   = ack_next_s;
    rden_next_s   = 1'b0;
    ramp_next_s   = 1'b0;
    smpsel_next_s = SMP_ZERO;
    case (state_next_s)
      ST_SETTLE: begin
        busy_next_s = 1'b1;
        rden_next_s = 1'b1;
      end
      ST_CONVERT: begin
        busy_next_s = 1'b1;
        rden_next_s = 1'b1;
        ramp_next_s = 1'b1;
      end
      ST_SELECT, ST_CAPTURE, ST_HANDOFF: begin
        busy_next_s   = 1'b1;
        rden_next_s   = 1'b1;
        smpsel_next_s = index_next_s;
      end
      ST_IDLE, ST_DONE: begin
        rden_next_s = 1'b0;
      end
      default: begin
        busy_next_s = 1'b0;
      end
    endcase
    if (rden_next_s) begin
      rdaddr_next_s = block_next_s;
    end else begin
      rdaddr_next_s = BLOCK_ZERO;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ack_o     <= 1'b0;
      busy_o       <= 1'b0;
      irs_rdaddr_o <= BLOCK_ZERO;
      irs_rden_o   <= 1'b0;
      irs_ramp_o   <= 1'b0;
      irs_start_o  <= 1'b0;
      irs_smpsel_o <= SMP_ZERO;
      dat_o        <= DAT_ZERO;
      dat_valid_o  <= 1'b0;
      dat_last_o   <= 1'b0;
    end else begin
      rd_ack_o     <= ack_next_s;
      busy_o       <= busy_next_s;
      irs_rdaddr_o <= rdaddr_next_s;
      irs_rden_o   <= rden_next_s;
      irs_ramp_o   <= ramp_next_s;
      irs_start_o  <= ramp_next_s;
      irs_smpsel_o <= smpsel_next_s;
      dat_o        <= dat_next_s;
      dat_valid_o  <= valid_next_s;
      dat_last_o   <= last_next_s;
    end
  end

endmodule

// File: tb/tb_irs_block_reader.sv
// Directed self-checking bench for irs_block_reader: default build plus a
// small 4-sample instance. Honours IRS_RD_TESTPATTERN_EN in its expectations.
module tb_irs_block_reader;

  localparam int NS  = 64;
  localparam int SC  = 8;
  localparam int CC  = 256;
  localparam int SW  = 2;
  localparam int NS2 = 4;
  localparam int SW2 = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, rd_ack, busy, rden, ramp, start, dat_valid, dat_last, dat_ready;
  logic [8:0]  rd_block, rdaddr;
  logic [5:0]  smpsel;
  logic [11:0] irs_dat, dat;

  logic        rd_req2, rd_ack2, busy2, rden2, ramp2, start2, dat_valid2, dat_last2;
  logic [8:0]  rdaddr2;
  logic [5:0]  smpsel2;
  logic [11:0] irs_dat2, dat2;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: each sample select returns a distinct, index-derived code.
  assign irs_dat  = {smpsel, smpsel ^ 6'h2A};
  assign irs_dat2 = 12'(smpsel2) * 12'd3;

  irs_block_reader #(.NUM_SAMPLES(NS), .SETTLE_CYCLES(SC), .CONV_CYCLES(CC), .SMP_WAIT(SW)) dut (
    .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req), .rd_block_i(rd_block), .rd_ack_o(rd_ack),
    .busy_o(busy), .irs_rdaddr_o(rdaddr), .irs_rden_o(rden), .irs_ramp_o(ramp),
    .irs_start_o(start), .irs_smpsel_o(smpsel), .irs_dat_i(irs_dat), .dat_o(dat),
    .dat_valid_o(dat_valid), .dat_last_o(dat_last), .dat_ready_i(dat_ready));

  irs_block_reader #(.NUM_SAMPLES(NS2), .SETTLE_CYCLES(SC), .CONV_CYCLES(CC), .SMP_WAIT(SW2)) dut_small (
    .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req2), .rd_block_i(9'h012), .rd_ack_o(rd_ack2),
    .busy_o(busy2), .irs_rdaddr_o(rdaddr2), .irs_rden_o(rden2), .irs_ramp_o(ramp2),
    .irs_start_o(start2), .irs_smpsel_o(smpsel2), .irs_dat_i(irs_dat2), .dat_o(dat2),
    .dat_valid_o(dat_valid2), .dat_last_o(dat_last2), .dat_ready_i(1'b1));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_dat(input logic [8:0] blk, input int k);
`ifdef IRS_RD_TESTPATTERN_EN
    return {blk[5:0], 6'(k)};
`else
    return {6'(k), 6'(k) ^ 6'h2A};
`endif
  endfunction

  function automatic logic [11:0] exp_dat2(input int k);
`ifdef IRS_RD_TESTPATTERN_EN
    return {6'h12, 6'(k)};
`else
    return 12'(k * 3);
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check_value({tag, "_ctrl"}, 32'({rd_ack, busy, rdaddr, rden, ramp, start, smpsel}), 32'd0);
    check_value({tag, "_data"}, 32'({dat, dat_valid, dat_last}), 32'd0);
  endtask

  // One full block read; stall_idx selects a sample to hold off for 10 cycles.
  task automatic run_block(input logic [8:0] blk, input int stall_idx);
    int t0, tprev, ramp_first, ramp_cnt, bad;
    rd_block = blk;
    rd_req = 1'b1;
    t0 = cyc;
    tick();
    check_value("ack_pulse", 32'(rd_ack), 32'd1);
    check_value("busy_on_ack", 32'(busy), 32'd1);
    check_value("rden_on_ack", 32'(rden), 32'd0);
    rd_req = 1'b0;
    tick();
    check_value("ack_single", 32'(rd_ack), 32'd0);
    check_value("rden_T2", 32'(rden), 32'd1);
    check_value("rdaddr_T2", 32'(rdaddr), 32'(blk));
    ramp_first = 0;
    ramp_cnt = 0;
    bad = 0;
    for (int i = 0; i < 400 && !dat_valid; i++) begin
      if (ramp) begin
        if (ramp_cnt == 0) ramp_first = cyc - t0;
        ramp_cnt++;
      end
      if (ramp !== start || rden !== 1'b1 || rdaddr !== blk) bad++;
      tick();
    end
    check_value("first_valid_lat", 32'(cyc - t0), 32'(SC + CC + SW + 3));
    check_value("ramp_start_off", 32'(ramp_first), 32'(SC + 2));
    check_value("ramp_len", 32'(ramp_cnt), 32'(CC));
    check_value("pins_stable", 32'(bad), 32'd0);
    tprev = cyc;
    for (int k = 0; k < NS; k++) begin
      if (k > 0) begin
        for (int i = 0; i < 20 && !dat_valid; i++) tick();
      end
      check_value("sample_valid", 32'(dat_valid), 32'd1);
      check_value("sample_dat", 32'(dat), 32'(exp_dat(blk, k)));
      check_value("sample_last", 32'(dat_last), 32'(k == NS - 1));
      check_value("sample_smpsel", 32'(smpsel), 32'(k));
      if (k == 1) check_value("sample_period", 32'(cyc - tprev), 32'(SW + 2));
      tprev = cyc;
      if (k == stall_idx) begin
        dat_ready = 1'b0;
        bad = 0;
        repeat (10) begin
          tick();
          if (dat_valid !== 1'b1 || dat !== exp_dat(blk, k) || smpsel !== 6'(k)) bad++;
        end
        check_value("stall_hold", 32'(bad), 32'd0);
        dat_ready = 1'b1;
      end
      tick();
      check_value("valid_drop", 32'(dat_valid), 32'd0);
    end
    check_value("done_rden", 32'(rden), 32'd0);
    check_value("done_busy", 32'(busy), 32'd0);
    check_value("done_rdaddr", 32'(rdaddr), 32'd0);
    check_value("done_smpsel", 32'(smpsel), 32'd0);
    tick();
  endtask

  initial begin
    int acks, ack1_cyc, ack2_cyc, done_cyc, t0;
    logic busy_prev;
    rst = 1'b1;
    rd_req = 1'b0;
    rd_req2 = 1'b0;
    rd_block = 9'h000;
    dat_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Full block with a 10-cycle downstream stall on sample 5.
    run_block(9'h1A5, 5);

    // Request held high across two blocks.
    rd_block = 9'h055;
    rd_req = 1'b1;
    acks = 0;
    ack1_cyc = 0;
    ack2_cyc = 0;
    done_cyc = 0;
    busy_prev = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (rd_ack) begin
        acks++;
        if (acks == 1) ack1_cyc = cyc;
        if (acks == 2) begin
          ack2_cyc = cyc;
          rd_req = 1'b0;
        end
      end
      if (acks == 1 && busy_prev && !busy && done_cyc == 0) done_cyc = cyc;
      busy_prev = busy;
    end
    check_value("held_ack_count", 32'(acks), 32'd2);
    check_value("held_first_done", 32'(done_cyc - ack1_cyc), 32'(SC + CC + NS * (SW + 2) + 1));
    check_value("held_reack_gap", 32'(ack2_cyc - done_cyc), 32'd2);
    check_value("held_end_busy", 32'(busy), 32'd0);

    // Reset during CONVERT.
    rd_block = 9'h0AA;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 40 && !ramp; i++) tick();
    check_value("reach_convert", 32'(ramp), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_convert");
    rst = 1'b0;
    tick();
    check_all_zero("after_rst_convert");

    // Reset during HANDOFF with the first sample waiting on ready.
    dat_ready = 1'b0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 400 && !dat_valid; i++) tick();
    check_value("reach_handoff", 32'(dat_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("rst_handoff");
    rst = 1'b0;
    dat_ready = 1'b1;
    tick();
    check_all_zero("after_rst_handoff");

    // A fresh request completes normally; block 0x03F also covers the test pattern.
    run_block(9'h03F, -1);

    // Small instance: 4 samples, SMP_WAIT=1.
    rd_req2 = 1'b1;
    t0 = cyc;
    tick();
    rd_req2 = 1'b0;
    for (int i = 0; i < 400 && !dat_valid2; i++) tick();
    check_value("small_first_lat", 32'(cyc - t0), 32'(2 + SC + CC + 2));
    for (int k = 0; k < NS2; k++) begin
      if (k > 0) begin
        for (int i = 0; i < 20 && !dat_valid2; i++) tick();
      end
      check_value("small_valid", 32'(dat_valid2), 32'd1);
      check_value("small_dat", 32'(dat2), 32'(exp_dat2(k)));
      check_value("small_last", 32'(dat_last2), 32'(k == NS2 - 1));
      tick();
    end
    check_value("small_done_ctrl",
                32'({rd_ack2, busy2, rdaddr2, rden2, ramp2, start2, smpsel2, dat_valid2}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
